mano_seq_dcd: RTL

- Timing and opcode decode unit for the Mano control path.
- Holds the sequence counter (SC) and a latched opcode register.
- Produces registered one-hot timing signals T[] and opcode signals D[].
- Generalises the fixed 3-to-8 decode: counter width, opcode width, enable gating, load/clear control and an optional fault-tolerance one-hot checker.

---
 rtl/mano_seq_dcd_pkg.sv | 11 +
 rtl/mano_seq_dcd_dcd_n.sv | 12 +
 rtl/mano_seq_dcd.sv | 75 +++++++
 3 files changed

// File: rtl/mano_seq_dcd_pkg.sv
// mano_seq_dcd_pkg: shared widths, timing indices and one-hot helper for the Mano sequence/opcode decoder.
package mano_seq_dcd_pkg;
  localparam int SC_W_DEF = 4;
  localparam int OP_W_DEF = 3;
  localparam int T_FETCH  = 0;
  localparam int T_DECODE = 2;
  localparam int OH_MAX   = 256;
  function automatic logic [OH_MAX-1:0] onehot(input int unsigned n);
    return {{(OH_MAX-1){1'b0}}, 1'b1} << n;
  endfunction
endpackage

// File: rtl/mano_seq_dcd_dcd_n.sv
// dcd_n: parametrised combinational N-to-2**N one-hot decoder.
module dcd_n #(
  parameter int N = 3
) (
  input  logic [N-1:0]      i_sel,
  output logic [2**N-1:0]   o_onehot
);
  always_comb begin
    o_onehot = '0;
    o_onehot[i_sel] = 1'b1;
  end
endmodule

// File: rtl/mano_seq_dcd.sv
// mano_seq_dcd: Mano sequence counter with registered one-hot T/D decode; MANO_ONEHOT_CHK_EN adds a sticky one-hot checker on err.
module mano_seq_dcd
  import mano_seq_dcd_pkg::*;
#(
  parameter int SC_W = SC_W_DEF,
  parameter int OP_W = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              inr,
  input  logic              load,
  input  logic [SC_W-1:0]   load_val,
  input  logic              op_ld,
  input  logic [OP_W-1:0]   op,
  output logic [SC_W-1:0]   sc,
  output logic [2**SC_W-1:0] T,
  output logic [2**OP_W-1:0] D,
  output logic              wrap,
  output logic              err
);
  localparam int NT = 2**SC_W;
  localparam int ND = 2**OP_W;
  logic [SC_W-1:0] r_sc, w_sc_next;
  logic [OP_W-1:0] r_op;
  logic [NT-1:0]   r_t, w_t_next;
  logic [ND-1:0]   r_d, w_d_next;
  logic            r_wrap, w_ld_ok, w_inr_ok, w_wrap_next;
  assign w_ld_ok     = load & en;
  assign w_inr_ok    = inr & en;
  assign w_wrap_next = ~clr & ~w_ld_ok & w_inr_ok & (&r_sc);
  always_comb begin
    w_sc_next = clr ? '0 : w_ld_ok ? load_val : w_inr_ok ? r_sc + 1'b1 : r_sc;
  end
  // T is decoded from the next count so it always lines up with sc
  dcd_n #(.N(SC_W)) u_dcd_t (.i_sel(w_sc_next), .o_onehot(w_t_next));
  dcd_n #(.N(OP_W)) u_dcd_d (.i_sel(op),        .o_onehot(w_d_next));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sc   <= '0;
      r_t    <= NT'(onehot(T_FETCH));
      r_op   <= '0;
      r_d    <= ND'(onehot(0));
      r_wrap <= 1'b0;
    end else begin
      r_sc   <= w_sc_next;
      r_t    <= w_t_next;
      r_wrap <= w_wrap_next;
      if (op_ld) begin
        r_op <= op;
        r_d  <= w_d_next;
      end
    end
  end
`ifdef MANO_ONEHOT_CHK_EN
  logic r_err, w_bad;
  logic [NT-1:0] w_t_exp;
  logic [ND-1:0] w_d_exp;
  assign w_t_exp = NT'(onehot(32'(r_sc)));
  assign w_d_exp = ND'(onehot(32'(r_op)));
  assign w_bad   = (r_t != w_t_exp) | (r_d != w_d_exp) | ~$onehot(r_t) | ~$onehot(r_d);
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= r_err | w_bad;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif
  assign sc   = r_sc;
  assign T    = r_t & {NT{en}};
  assign D    = r_d & {ND{en}};
  assign wrap = r_wrap;
endmodule
